prio_rr_encoder: RTL and testbench
==================================

PRIO_RR_ENCODER -- requirements
Module: prio_rr_encoder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the request vector width (legal range 2..256).
REQ-002 The block SHALL have parameter ACTIVE_LOW, default 0; when 1, a request bit is active when i[n]=0.
REQ-003 The block SHALL have localparam IDXW = clog2(WIDTH), giving the index width.
REQ-004 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-005 Port: clk  input  1  rising-edge clock.
REQ-006 Port: rst  input  1  asynchronous active-high reset.
REQ-007 Port: i  input  WIDTH  request vector.
REQ-008 Port: in_valid  input  1  i is valid this cycle.
REQ-009 Port: in_ready  output  1  block accepts i this cycle.
REQ-010 Port: rr_mode  input  1  0 = fixed priority, 1 = round-robin; sampled at acceptance.
REQ-011 Port: out  output  IDXW  encoded winning index.
REQ-012 Port: none  output  1  accepted vector had no active bit.
REQ-013 Port: count  output  IDXW+1  number of active bits in the accepted vector.
REQ-014 Port: out_valid  output  1  out, none and count are valid.
REQ-015 Port: out_ready  input  1  downstream consumes the result.

Function
REQ-016 Acceptance SHALL occur when in_valid && in_ready at a rising clk edge.
REQ-017 in_ready SHALL equal !out_valid || out_ready, giving a one-entry skid-free output register with full throughput.
REQ-018 Latency SHALL be exactly 1 cycle: the result appears with out_valid=1 on the edge of acceptance.
REQ-019 out_valid SHALL set on acceptance, clear on out_valid && out_ready without a new acceptance, and stay 1 on simultaneous consume and accept.
REQ-020 While out_valid && !out_ready, out, none and count SHALL hold stable.
REQ-021 An active bit SHALL be i[n]^ACTIVE_LOW == 1.
REQ-022 Fixed mode: out SHALL be the highest active index.
REQ-023 Round-robin mode: out SHALL be the lowest active index >= ptr; if none exists, the lowest active index overall (wrap-around).
REQ-024 ptr (IDXW bits, internal) SHALL update only on acceptance in rr_mode=1 with at least one active bit.
REQ-025 On such an update, ptr SHALL become out+1, wrapping to 0 when out = WIDTH-1.
REQ-026 Fixed-mode acceptances SHALL leave ptr unchanged, so mode switching mid-stream resumes round-robin from the retained ptr.
REQ-027 An all-inactive vector SHALL produce none=1, out=0, count=0, and leave ptr unchanged.
REQ-028 count SHALL be the popcount of active bits, range 0..WIDTH.
REQ-029 When WIDTH is not a power of two, ptr SHALL never exceed WIDTH-1.
REQ-030 There SHALL be no combinational path from i to out; out_ready to in_ready is the only combinational path.

Reset
REQ-031 rst=1 SHALL asynchronously force out_valid=0, out=0, none=0, count=0 and ptr=0.
REQ-032 A result pending at reset SHALL be discarded.
REQ-033 in_ready SHALL be 1 during and after reset, per REQ-017.
REQ-034 The first acceptance after rst deasserts SHALL be evaluated with ptr=0.

Verification (WIDTH=32 unless stated)
REQ-035 Fixed mode, ACTIVE_LOW=1, i=0x7FFFEFFF -> active bits 31 and 12, out=31, count=2, none=0, one cycle after acceptance.
REQ-036 Fixed mode, ACTIVE_LOW=1, i=0xFFFFFFFF -> none=1, out=0, count=0.
REQ-037 Round-robin, ACTIVE_LOW=0, i=0x80000005 held for 4 acceptances after reset -> out sequence 0, 2, 31, 0 (ptr wraps from 31 to 0).
REQ-038 Backpressure: accept A (out=5), hold out_ready=0 for 3 cycles while in_valid=1 -> in_ready=0 and out stays 5; then out_ready=1 -> next vector accepted the same cycle and out_valid stays 1.
REQ-039 Round-robin with ptr=3 and rst pulsed asynchronously mid-cycle while out_valid=1 -> out_valid=0 immediately; next i=0x9 gives out=0.
REQ-040 WIDTH=5, round-robin, i=0x10 then 0x01 -> out=4 then out=0; ptr wraps to 0 and never reaches 5.

Source files
------------

// File: rtl/prio_rr_encoder.sv
// prio_rr_encoder
// Registered priority encoder with a valid/ready handshake on both sides.
// Each accepted request vector produces its winning index, a "no active bit"
// flag and a popcount one cycle later in a single-entry output register.
// Fixed mode picks the highest active index. Round-robin mode picks the
// lowest active index at or above an internal pointer, wrapping to the
// lowest active index overall. The pointer advances only on round-robin
// acceptances that have at least one active bit.

module prio_rr_encoder #(
  parameter int  WIDTH      = 32,
  parameter bit  ACTIVE_LOW = 1'b0,
  localparam int IDXW       = $clog2(WIDTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  i,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              rr_mode,
  output logic [IDXW-1:0]   out,
  output logic              none,
  output logic [IDXW:0]     count,
  output logic              out_valid,
  input  logic              out_ready
);

  // Highest legal index; the pointer wraps to zero after granting it, so it
  // never takes a value outside 0..WIDTH-1 even when WIDTH is not a power
  // of two.
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WIDTH - 1);

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic              out_valid_q, out_valid_d;
  logic [IDXW-1:0]   out_q,       out_d;
  logic              none_q,      none_d;
  logic [IDXW:0]     count_q,     count_d;
  logic [IDXW-1:0]   ptr_q,       ptr_d;

  // ---------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------
  logic [WIDTH-1:0]  active;
  logic              any_active;
  logic              accept;

  // Normalise polarity so everything downstream sees active-high requests.
  assign active     = i ^ {WIDTH{ACTIVE_LOW}};
  assign any_active = |active;

  // The output register frees up in the same cycle it is consumed, which
  // gives full throughput; out_ready -> in_ready is the only combinational
  // path through the block.
  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // ---------------------------------------------------------------------
  // Fixed priority: highest active index wins
  // ---------------------------------------------------------------------
  logic [IDXW-1:0] fix_idx;

  // Ascending scan; the last active bit seen is the highest one.
  always_comb begin
    // NOTE: every combinational output is given a default before any
    // conditional assignment, so no path can leave it unassigned and no
    // latch is inferred.
    fix_idx = '0;
    for (int n = 0; n < WIDTH; n++) begin
      if (active[n]) begin
        fix_idx = IDXW'(n);
      end
    end
  end

  // ---------------------------------------------------------------------
  // Round-robin: lowest active index >= ptr, else lowest active overall
  // ---------------------------------------------------------------------
  logic [IDXW-1:0] rr_ge_idx;
  logic            rr_ge_found;
  logic [IDXW-1:0] rr_any_idx;

  // Descending scan; the last hit in each category is the lowest index.
  always_comb begin
    rr_ge_idx   = '0;
    rr_ge_found = 1'b0;
    rr_any_idx  = '0;
    for (int n = WIDTH - 1; n >= 0; n--) begin
      if (active[n]) begin
        rr_any_idx = IDXW'(n);
        if (IDXW'(n) >= ptr_q) begin
          rr_ge_idx   = IDXW'(n);
          rr_ge_found = 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Population count of active bits (0..WIDTH)
  // ---------------------------------------------------------------------
  logic [IDXW:0] pop_cnt;

  // Plain adder chain; synthesis balances it into a tree.
  always_comb begin
    pop_cnt = '0;
    for (int n = 0; n < WIDTH; n++) begin
      pop_cnt = pop_cnt + (IDXW + 1)'(active[n]);
    end
  end

  // ---------------------------------------------------------------------
  // Winner selection
  // ---------------------------------------------------------------------
  logic [IDXW-1:0] win_idx;

  // An all-inactive vector reports index 0 regardless of mode.
  always_comb begin
    win_idx = '0;
    if (any_active) begin
      if (rr_mode) begin
        win_idx = rr_ge_found ? rr_ge_idx : rr_any_idx;
      end else begin
        win_idx = fix_idx;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------

  // Load a new result on acceptance, drain on consume, otherwise hold.
  always_comb begin
    out_valid_d = out_valid_q;
    out_d       = out_q;
    none_d      = none_q;
    count_d     = count_q;
    ptr_d       = ptr_q;

    if (accept) begin
      out_valid_d = 1'b1;
      out_d       = win_idx;
      none_d      = !any_active;
      count_d     = pop_cnt;
      // Only a round-robin grant moves the pointer; fixed-mode and empty
      // vectors leave it alone so round-robin resumes where it stopped.
      if (rr_mode && any_active) begin
        ptr_d = (win_idx == LAST_IDX) ? '0 : win_idx + IDXW'(1);
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // ---------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------

  // Result register and round-robin pointer; reset discards any pending
  // result and restarts the pointer at 0.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    if (rst) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
      none_q      <= 1'b0;
      count_q     <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      none_q      <= none_d;
      count_q     <= count_d;
      ptr_q       <= ptr_d;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign none      = none_q;
  assign count     = count_q;

endmodule

// File: tb/tb_prio_rr_encoder.sv
// tb_prio_rr_encoder
// Directed bench for prio_rr_encoder. Three instances: 32-bit active-low,
// 32-bit active-high and 5-bit active-high. Inputs change on the falling
// edge; outputs are sampled on the falling edge after the accepting edge.

module tb_prio_rr_encoder;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // 32-bit, active-low instance
  logic [31:0] a_i;
  logic        a_in_valid, a_in_ready, a_rr_mode;
  logic [4:0]  a_out;
  logic        a_none;
  logic [5:0]  a_count;
  logic        a_out_valid, a_out_ready;

  // 32-bit, active-high instance
  logic [31:0] r_i;
  logic        r_in_valid, r_in_ready, r_rr_mode;
  logic [4:0]  r_out;
  logic        r_none;
  logic [5:0]  r_count;
  logic        r_out_valid, r_out_ready;

  // 5-bit, active-high instance
  logic [4:0]  f_i;
  logic        f_in_valid, f_in_ready, f_rr_mode;
  logic [2:0]  f_out;
  logic        f_none;
  logic [3:0]  f_count;
  logic        f_out_valid, f_out_ready;

  prio_rr_encoder #(.WIDTH(32), .ACTIVE_LOW(1'b1)) u_al (
    .clk(clk), .rst(rst), .i(a_i), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .rr_mode(a_rr_mode), .out(a_out), .none(a_none), .count(a_count),
    .out_valid(a_out_valid), .out_ready(a_out_ready)
  );

  prio_rr_encoder #(.WIDTH(32), .ACTIVE_LOW(1'b0)) u_rr (
    .clk(clk), .rst(rst), .i(r_i), .in_valid(r_in_valid), .in_ready(r_in_ready),
    .rr_mode(r_rr_mode), .out(r_out), .none(r_none), .count(r_count),
    .out_valid(r_out_valid), .out_ready(r_out_ready)
  );

  prio_rr_encoder #(.WIDTH(5), .ACTIVE_LOW(1'b0)) u_w5 (
    .clk(clk), .rst(rst), .i(f_i), .in_valid(f_in_valid), .in_ready(f_in_ready),
    .rr_mode(f_rr_mode), .out(f_out), .none(f_none), .count(f_count),
    .out_valid(f_out_valid), .out_ready(f_out_ready)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One accepting rising edge, then settle to the next falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Absolute time bound on the whole run.
  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int exp_seq [4];
    exp_seq = '{0, 2, 31, 0};

    a_i = '0; a_in_valid = 1'b0; a_rr_mode = 1'b0; a_out_ready = 1'b1;
    r_i = '0; r_in_valid = 1'b0; r_rr_mode = 1'b0; r_out_ready = 1'b1;
    f_i = '0; f_in_valid = 1'b0; f_rr_mode = 1'b0; f_out_ready = 1'b1;

    // Reset state, sampled while rst is still high
    #12;
    check("rst_out_valid", r_out_valid, 0);
    check("rst_out",       r_out,       0);
    check("rst_none",      r_none,      0);
    check("rst_count",     r_count,     0);
    check("rst_in_ready",  r_in_ready,  1);

    @(negedge clk);
    rst = 1'b0;
    check("post_rst_in_ready", r_in_ready, 1);
    check("a_idle_out_valid",  a_out_valid, 0);

    // Fixed mode, active-low: bits 31 and 12 active
    a_i = 32'h7FFF_EFFF; a_in_valid = 1'b1; a_rr_mode = 1'b0;
    tick();
    check("al_fix_valid", a_out_valid, 1);
    check("al_fix_out",   a_out,       31);
    check("al_fix_count", a_count,     2);
    check("al_fix_none",  a_none,      0);

    // Fixed mode, active-low: nothing active
    a_i = 32'hFFFF_FFFF;
    tick();
    check("al_none_valid", a_out_valid, 1);
    check("al_none_none",  a_none,      1);
    check("al_none_out",   a_out,       0);
    check("al_none_count", a_count,     0);

    a_in_valid = 1'b0;
    tick();
    check("al_drain_valid", a_out_valid, 0);

    // Round-robin over bits 0, 2, 31 with pointer wrap
    r_i = 32'h8000_0005; r_rr_mode = 1'b1; r_in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("rr_seq%0d_out", k), r_out, exp_seq[k]);
      check($sformatf("rr_seq%0d_count", k), r_count, 3);
    end

    // Fixed-mode acceptance in between leaves ptr at 1
    r_rr_mode = 1'b0;
    tick();
    check("mix_fix_out", r_out, 31);

    r_rr_mode = 1'b1; r_i = 32'h0000_0005;
    tick();
    check("mix_rr_resume_out", r_out, 2);

    // Empty vector in rr mode: ptr stays 3
    r_i = 32'h0;
    tick();
    check("rr_empty_none",  r_none,  1);
    check("rr_empty_out",   r_out,   0);
    check("rr_empty_count", r_count, 0);

    // Hold the result, then reset asynchronously mid-cycle
    r_in_valid = 1'b0; r_out_ready = 1'b0;
    tick();
    check("hold_before_rst_valid", r_out_valid, 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_valid",    r_out_valid, 0);
    check("async_rst_none",     r_none,      0);
    check("async_rst_in_ready", r_in_ready,  1);
    #1 rst = 1'b0;
    @(negedge clk);

    // First acceptance after reset uses ptr=0 (would be 3 otherwise)
    r_out_ready = 1'b1; r_i = 32'h0000_0009; r_in_valid = 1'b1; r_rr_mode = 1'b1;
    tick();
    check("post_rst_rr_valid", r_out_valid, 1);
    check("post_rst_rr_out",   r_out,       0);

    // Backpressure
    r_rr_mode = 1'b0; r_i = 32'h0000_0020;
    tick();
    check("bp_a_out", r_out, 5);
    r_out_ready = 1'b0; r_i = 32'h0000_0100;
    #1;
    check("bp_in_ready_low", r_in_ready, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("bp_hold%0d_valid", k), r_out_valid, 1);
      check($sformatf("bp_hold%0d_out", k),   r_out,       5);
      check($sformatf("bp_hold%0d_ready", k), r_in_ready,  0);
    end
    r_out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", r_in_ready, 1);
    tick();
    check("bp_next_valid", r_out_valid, 1);
    check("bp_next_out",   r_out,       8);
    r_in_valid = 1'b0;
    tick();
    check("bp_drain_valid", r_out_valid, 0);

    // WIDTH=5 round-robin with wrap from index 4
    f_rr_mode = 1'b1; f_in_valid = 1'b1; f_i = 5'h10;
    tick();
    check("w5_out_4", f_out, 4);
    f_i = 5'h01;
    tick();
    check("w5_out_0", f_out, 0);
    f_i = 5'h03;
    tick();
    check("w5_out_1", f_out, 1);
    f_i = 5'h1F;
    tick();
    check("w5_full_out",   f_out,   2);
    check("w5_full_count", f_count, 5);
    check("w5_full_none",  f_none,  0);
    f_in_valid = 1'b0;
    tick();
    check("w5_drain_valid", f_out_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
